multicycle_ctrl_unit: RTL and testbench

Parametrised control unit for the processor datapath. It decodes the 5-bit opcode and ALU-op fields into datapath control flags. It adds a two-state sequencer that stalls the PC while the external multiply/divide unit runs, with an optional timeout. Overflow and mult/div exceptions are redirected to `$rstatus` (r30) with a code.

---
 rtl/multicycle_ctrl_unit_pkg.sv | 74 +++++++
 rtl/multicycle_ctrl_unit_if.sv | 46 ++++
 rtl/multicycle_ctrl_unit_ctrl_decode.sv | 84 ++++++++
 rtl/multicycle_ctrl_unit.sv | 153 +++++++++++++++
 tb/tb_multicycle_ctrl_unit.sv | 209 ++++++++++++++++++++
 5 files changed

// File: rtl/multicycle_ctrl_unit_pkg.sv
// Shared definitions for the multicycle control unit.
// Contents: opcode and ALU-op codes, dst_sel and wd_sel encodings, exception codes,
// sequencer state encoding, and the decoded-control struct that passes from ctrl_decode to
// the top level.
package proc_ctrl_pkg;

  // Opcodes (5-bit)
  localparam logic [4:0] OpRtype = 5'b00000;
  localparam logic [4:0] OpJ     = 5'b00001;
  localparam logic [4:0] OpBne   = 5'b00010;
  localparam logic [4:0] OpJal   = 5'b00011;
  localparam logic [4:0] OpJr    = 5'b00100;
  localparam logic [4:0] OpAddi  = 5'b00101;
  localparam logic [4:0] OpBlt   = 5'b00110;
  localparam logic [4:0] OpSw    = 5'b00111;
  localparam logic [4:0] OpLw    = 5'b01000;
  localparam logic [4:0] OpSetx  = 5'b10101;
  localparam logic [4:0] OpBex   = 5'b10110;

  // R-type ALU-op values that the control unit treats specially
  localparam logic [4:0] AluAdd = 5'b00000;
  localparam logic [4:0] AluSub = 5'b00001;
  localparam logic [4:0] AluMul = 5'b00110;
  localparam logic [4:0] AluDiv = 5'b00111;

  // Write destination
  localparam logic [1:0] DstRd      = 2'd0;
  localparam logic [1:0] DstRstatus = 2'd1;
  localparam logic [1:0] DstRa      = 2'd2;

  // Write-data source
  localparam logic [2:0] WdAlu    = 3'd0;
  localparam logic [2:0] WdDmem   = 3'd1;
  localparam logic [2:0] WdMd     = 3'd2;
  localparam logic [2:0] WdStatus = 3'd3;
  localparam logic [2:0] WdImmT   = 3'd4;
  localparam logic [2:0] WdPcInc  = 3'd5;

  // Exception codes written to $rstatus
  localparam logic [2:0] ExcAdd       = 3'd1;
  localparam logic [2:0] ExcAddi      = 3'd2;
  localparam logic [2:0] ExcSub       = 3'd3;
  localparam logic [2:0] ExcMul       = 3'd4;
  localparam logic [2:0] ExcDiv       = 3'd5;
  localparam logic [2:0] ExcMdTimeout = 3'd6;

  // Sequencer states
  localparam logic [0:0] StIdle   = 1'b0;
  localparam logic [0:0] StMdWait = 1'b1;

  // Static decode of one instruction; ovf_* mark the ops that can raise an overflow
  typedef struct packed {
    logic       rwe;
    logic       rtar;
    logic [1:0] dst_sel;
    logic [2:0] wd_sel;
    logic       alu_inb;
    logic [4:0] alu_opctrl;
    logic       dmwe;
    logic       br_bne;
    logic       br_blt;
    logic       br_bex;
    logic       j;
    logic       jr;
    logic       jal;
    logic       setx;
    logic       md_mult;
    logic       md_div;
    logic       ovf_add;
    logic       ovf_addi;
    logic       ovf_sub;
  } ctrl_dec_t;

endpackage

// File: rtl/multicycle_ctrl_unit_if.sv
// Control-unit bus: instruction fields and status inputs towards the control unit, datapath
// control flags back. The slave modport is the control unit; master is the driving side.
// Clock and reset are not part of this bundle.
interface multicycle_ctrl_unit_if #(
  parameter int unsigned OPW      = 5,
  parameter int unsigned STATUS_W = 32
);
  logic                instr_valid;
  logic [OPW-1:0]      opcode;
  logic [4:0]          alu_op;
  logic                overflow;
  logic                md_ready;
  logic                md_exception;

  logic                rwe;
  logic                rtar;
  logic [1:0]          dst_sel;
  logic [2:0]          wd_sel;
  logic [STATUS_W-1:0] status_code;
  logic                alu_inb;
  logic [4:0]          alu_opctrl;
  logic                dmwe;
  logic                br_bne;
  logic                br_blt;
  logic                br_bex;
  logic                j;
  logic                jr;
  logic                jal;
  logic                setx;
  logic                md_start_mult;
  logic                md_start_div;
  logic                stall;

  modport slave (
    input  instr_valid, opcode, alu_op, overflow, md_ready, md_exception,
    output rwe, rtar, dst_sel, wd_sel, status_code, alu_inb, alu_opctrl, dmwe,
           br_bne, br_blt, br_bex, j, jr, jal, setx, md_start_mult, md_start_div, stall
  );

  modport master (
    output instr_valid, opcode, alu_op, overflow, md_ready, md_exception,
    input  rwe, rtar, dst_sel, wd_sel, status_code, alu_inb, alu_opctrl, dmwe,
           br_bne, br_blt, br_bex, j, jr, jal, setx, md_start_mult, md_start_div, stall
  );

endinterface

// File: rtl/multicycle_ctrl_unit_ctrl_decode.sv
// ctrl_decode: purely combinational opcode/ALU-op decode into static control flags.
// Ports:
//   opcode_i  instruction opcode (OPW bits)
//   alu_op_i  R-type ALU-op field
//   dec_o     decoded flags; undecoded opcodes give all zeros
module ctrl_decode
  import proc_ctrl_pkg::*;
#(
  parameter int unsigned OPW = 5
) (
  input  logic [OPW-1:0] opcode_i,
  input  logic [4:0]     alu_op_i,
  output ctrl_dec_t      dec_o
);

  always_comb begin
    dec_o = '0;
    case (opcode_i)
      OPW'(OpRtype): begin
        dec_o.alu_opctrl = alu_op_i;
        dec_o.md_mult    = (alu_op_i == AluMul);
        dec_o.md_div     = (alu_op_i == AluDiv);
        // mul/div results are written later by the sequencer, not in the issue cycle
        dec_o.rwe        = !((alu_op_i == AluMul) || (alu_op_i == AluDiv));
        dec_o.ovf_add    = (alu_op_i == AluAdd);
        dec_o.ovf_sub    = (alu_op_i == AluSub);
      end
      OPW'(OpAddi): begin
        dec_o.rwe      = 1'b1;
        dec_o.alu_inb  = 1'b1;
        dec_o.ovf_addi = 1'b1;
      end
      OPW'(OpSw): begin
        dec_o.rtar    = 1'b1;
        dec_o.alu_inb = 1'b1;
        dec_o.dmwe    = 1'b1;
      end
      OPW'(OpLw): begin
        dec_o.rwe     = 1'b1;
        dec_o.alu_inb = 1'b1;
        dec_o.wd_sel  = WdDmem;
      end
      OPW'(OpJ): begin
        dec_o.j          = 1'b1;
        dec_o.alu_opctrl = alu_op_i;
      end
      OPW'(OpBne): begin
        dec_o.br_bne     = 1'b1;
        dec_o.rtar       = 1'b1;
        dec_o.alu_opctrl = alu_op_i;
      end
      OPW'(OpJal): begin
        dec_o.jal        = 1'b1;
        dec_o.rwe        = 1'b1;
        dec_o.dst_sel    = DstRa;
        dec_o.wd_sel     = WdPcInc;
        dec_o.alu_opctrl = alu_op_i;
      end
      OPW'(OpJr): begin
        dec_o.jr         = 1'b1;
        dec_o.rtar       = 1'b1;
        dec_o.alu_opctrl = alu_op_i;
      end
      OPW'(OpBlt): begin
        dec_o.br_blt     = 1'b1;
        dec_o.rtar       = 1'b1;
        dec_o.alu_opctrl = alu_op_i;
      end
      OPW'(OpSetx): begin
        dec_o.setx       = 1'b1;
        dec_o.rwe        = 1'b1;
        dec_o.dst_sel    = DstRstatus;
        dec_o.wd_sel     = WdImmT;
        dec_o.alu_opctrl = alu_op_i;
      end
      OPW'(OpBex): begin
        dec_o.br_bex     = 1'b1;
        dec_o.alu_opctrl = alu_op_i;
      end
      default: ;
    endcase
  end

endmodule

// File: rtl/multicycle_ctrl_unit.sv
// multicycle_ctrl_unit: datapath control unit with a two-state mult/div sequencer.
// IDLE decodes instructions combinationally; a valid mul/div pulses md_start_* and moves to
// MD_WAIT, where the PC is stalled until md_ready. Overflow and mult/div exceptions are
// redirected to $rstatus with a code on status_code.
// Ports:
//   clock  rising-edge clock
//   reset  asynchronous active-low reset; forces every output to zero while low
//   bus    multicycle_ctrl_unit_if.slave (instruction fields in, control flags out)
// Build option: define MULTICYCLE_CTRL_TIMEOUT_EN to abandon MD_WAIT after MD_MAX_CYCLES
// cycles with exception code 6; otherwise MD_WAIT waits indefinitely.
module multicycle_ctrl_unit
  import proc_ctrl_pkg::*;
#(
  parameter int unsigned OPW           = 5,
  parameter int unsigned STATUS_W      = 32,
  parameter int unsigned MD_MAX_CYCLES = 40
) (
  input logic                  clock,
  input logic                  reset,
  multicycle_ctrl_unit_if.slave bus
);

  ctrl_dec_t  dec;
  ctrl_dec_t  ctl;
  logic       stall;
  logic [2:0] exc;

  logic [0:0] state_q, state_d;
  logic       is_div_q, is_div_d;

`ifdef MULTICYCLE_CTRL_TIMEOUT_EN
  localparam int unsigned CntW = $clog2(MD_MAX_CYCLES);
  logic [CntW-1:0] cnt_q, cnt_d;
`else
  logic unused_max_cycles;
  assign unused_max_cycles = ^MD_MAX_CYCLES;
`endif

  ctrl_decode #(
    .OPW (OPW)
  ) u_decode (
    .opcode_i (bus.opcode),
    .alu_op_i (bus.alu_op),
    .dec_o    (dec)
  );

  always_comb begin
    ctl      = '0;
    stall    = 1'b0;
    exc      = '0;
    state_d  = state_q;
    is_div_d = is_div_q;
`ifdef MULTICYCLE_CTRL_TIMEOUT_EN
    cnt_d    = cnt_q;
`endif
    case (state_q)
      StIdle: begin
        if (bus.instr_valid) begin
          ctl = dec;
          if (dec.md_mult || dec.md_div) begin
            stall    = 1'b1;
            state_d  = StMdWait;
            is_div_d = dec.md_div;
`ifdef MULTICYCLE_CTRL_TIMEOUT_EN
            cnt_d    = '0;
`endif
          end else if (bus.overflow && (dec.ovf_add || dec.ovf_addi || dec.ovf_sub)) begin
            ctl.dst_sel = DstRstatus;
            ctl.wd_sel  = WdStatus;
            exc = dec.ovf_add ? ExcAdd : (dec.ovf_addi ? ExcAddi : ExcSub);
          end
        end
      end
      StMdWait: begin
        // md_ready is checked first so it wins over a coincident timeout
        if (bus.md_ready) begin
          ctl.rwe = 1'b1;
          state_d = StIdle;
          if (bus.md_exception) begin
            ctl.dst_sel = DstRstatus;
            ctl.wd_sel  = WdStatus;
            exc         = is_div_q ? ExcDiv : ExcMul;
          end else begin
            ctl.dst_sel = DstRd;
            ctl.wd_sel  = WdMd;
          end
        end
`ifdef MULTICYCLE_CTRL_TIMEOUT_EN
        else if (cnt_q == CntW'(MD_MAX_CYCLES - 1)) begin
          ctl.rwe     = 1'b1;
          ctl.dst_sel = DstRstatus;
          ctl.wd_sel  = WdStatus;
          exc         = ExcMdTimeout;
          state_d     = StIdle;
        end else begin
          stall = 1'b1;
          cnt_d = cnt_q + CntW'(1);
        end
`else
        else begin
          stall = 1'b1;
        end
`endif
      end
    endcase
    // Outputs are forced quiet while reset is held, whatever the inputs do
    if (!reset) begin
      ctl   = '0;
      stall = 1'b0;
      exc   = '0;
    end
  end

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      state_q  <= StIdle;
      is_div_q <= 1'b0;
    end else begin
      state_q  <= state_d;
      is_div_q <= is_div_d;
    end
  end

`ifdef MULTICYCLE_CTRL_TIMEOUT_EN
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end
`endif

  assign bus.rwe           = ctl.rwe;
  assign bus.rtar          = ctl.rtar;
  assign bus.dst_sel       = ctl.dst_sel;
  assign bus.wd_sel        = ctl.wd_sel;
  assign bus.status_code   = STATUS_W'(exc);
  assign bus.alu_inb       = ctl.alu_inb;
  assign bus.alu_opctrl    = ctl.alu_opctrl;
  assign bus.dmwe          = ctl.dmwe;
  assign bus.br_bne        = ctl.br_bne;
  assign bus.br_blt        = ctl.br_blt;
  assign bus.br_bex        = ctl.br_bex;
  assign bus.j             = ctl.j;
  assign bus.jr            = ctl.jr;
  assign bus.jal           = ctl.jal;
  assign bus.setx          = ctl.setx;
  assign bus.md_start_mult = ctl.md_mult;
  assign bus.md_start_div  = ctl.md_div;
  assign bus.stall         = stall;

endmodule

// File: tb/tb_multicycle_ctrl_unit.sv
// Bench for multicycle_ctrl_unit. Each cycle the driver applies inputs and pushes the expected
// output vector; a negedge monitor pops and compares against the DUT outputs.
module tb_multicycle_ctrl_unit;

  localparam int unsigned MaxCycles = 8;

  localparam logic [4:0] OpR = 5'b00000, OpJ = 5'b00001, OpBne = 5'b00010, OpJal = 5'b00011;
  localparam logic [4:0] OpJr = 5'b00100, OpAddi = 5'b00101, OpBlt = 5'b00110;
  localparam logic [4:0] OpSw = 5'b00111, OpLw = 5'b01000, OpSetx = 5'b10101;
  localparam logic [4:0] OpBex = 5'b10110;

  // Flag bit positions in the packed expected vector
  localparam logic [13:0] FlRwe = 14'h0001, FlRtar = 14'h0002, FlAluInb = 14'h0004;
  localparam logic [13:0] FlDmwe = 14'h0008, FlBne = 14'h0010, FlBlt = 14'h0020;
  localparam logic [13:0] FlBex = 14'h0040, FlJ = 14'h0080, FlJr = 14'h0100;
  localparam logic [13:0] FlJal = 14'h0200, FlSetx = 14'h0400, FlMult = 14'h0800;
  localparam logic [13:0] FlDiv = 14'h1000, FlStall = 14'h2000;

  logic clock = 1'b0;
  logic reset = 1'b0;

  int n_checks = 0;
  int n_errors = 0;

  logic [55:0] exp_q[$];
  string       tag_q[$];
  logic [55:0] obs;

  multicycle_ctrl_unit_if #(.OPW(5), .STATUS_W(32)) bus ();

  multicycle_ctrl_unit #(
    .OPW           (5),
    .STATUS_W      (32),
    .MD_MAX_CYCLES (MaxCycles)
  ) dut (
    .clock (clock),
    .reset (reset),
    .bus   (bus)
  );

  always #5 clock = ~clock;

  assign obs = {bus.stall, bus.md_start_div, bus.md_start_mult, bus.setx, bus.jal, bus.jr,
                bus.j, bus.br_bex, bus.br_blt, bus.br_bne, bus.dmwe, bus.alu_inb, bus.rtar,
                bus.rwe, bus.dst_sel, bus.wd_sel, bus.alu_opctrl, bus.status_code};

  function automatic logic [55:0] exp_of(input logic [13:0] fl, input logic [1:0] dst,
                                         input logic [2:0] wd, input logic [4:0] alu,
                                         input logic [31:0] code);
    return {fl, dst, wd, alu, code};
  endfunction

  task automatic check_value(input string tag, input logic [55:0] got, input logic [55:0] want);
    n_checks++;
    if (got !== want) begin
      n_errors++;
      $display("FAIL %s: got %h expected %h", tag, got, want);
    end
  endtask

  task automatic drive(input logic v, input logic [4:0] op, input logic [4:0] aop,
                       input logic ovf, input logic rdy, input logic exc);
    bus.instr_valid  = v;
    bus.opcode       = op;
    bus.alu_op       = aop;
    bus.overflow     = ovf;
    bus.md_ready     = rdy;
    bus.md_exception = exc;
  endtask

  // Queue the expectation for the inputs just driven, then advance one cycle
  task automatic step(input string tag, input logic [55:0] e);
    exp_q.push_back(e);
    tag_q.push_back(tag);
    @(posedge clock);
    #1;
  endtask

  always @(negedge clock) begin
    if (exp_q.size() > 0) begin
      check_value(tag_q.pop_front(), obs, exp_q.pop_front());
    end
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    drive(1'b1, 5'h1f, 5'h1f, 1'b1, 1'b1, 1'b1);
    @(posedge clock);
    #1;
    // Reset held low: everything quiet even with all inputs high or a mul offered
    step("rst_allhigh", '0);
    drive(1'b1, OpR, 5'd6, 1'b1, 1'b1, 1'b1);
    step("rst_mul", '0);

    reset = 1'b1;
    drive(1'b1, OpR, 5'd2, 1'b1, 1'b0, 1'b0);
    step("r_op2_ovf_ignored", exp_of(FlRwe, 2'd0, 3'd0, 5'd2, 32'd0));
    drive(1'b1, OpR, 5'd0, 1'b0, 1'b0, 1'b0);
    step("add_plain", exp_of(FlRwe, 2'd0, 3'd0, 5'd0, 32'd0));
    drive(1'b1, OpR, 5'd0, 1'b1, 1'b0, 1'b0);
    step("add_ovf", exp_of(FlRwe, 2'd1, 3'd3, 5'd0, 32'd1));
    drive(1'b1, OpAddi, 5'd3, 1'b1, 1'b0, 1'b0);
    step("addi_ovf", exp_of(FlRwe | FlAluInb, 2'd1, 3'd3, 5'd0, 32'd2));
    drive(1'b1, OpR, 5'd1, 1'b1, 1'b0, 1'b0);
    step("sub_ovf", exp_of(FlRwe, 2'd1, 3'd3, 5'd1, 32'd3));
    drive(1'b0, OpAddi, 5'd0, 1'b1, 1'b1, 1'b1);
    step("invalid", '0);

    // Opcode sweep
    drive(1'b1, OpSw, 5'd5, 1'b0, 1'b0, 1'b0);
    step("sw", exp_of(FlRtar | FlAluInb | FlDmwe, 2'd0, 3'd0, 5'd0, 32'd0));
    drive(1'b1, OpLw, 5'd5, 1'b0, 1'b0, 1'b0);
    step("lw", exp_of(FlRwe | FlAluInb, 2'd0, 3'd1, 5'd0, 32'd0));
    drive(1'b1, OpJ, 5'd3, 1'b0, 1'b0, 1'b0);
    step("j", exp_of(FlJ, 2'd0, 3'd0, 5'd3, 32'd0));
    drive(1'b1, OpBne, 5'd1, 1'b1, 1'b0, 1'b0);
    step("bne", exp_of(FlBne | FlRtar, 2'd0, 3'd0, 5'd1, 32'd0));
    drive(1'b1, OpJal, 5'd0, 1'b0, 1'b0, 1'b0);
    step("jal", exp_of(FlJal | FlRwe, 2'd2, 3'd5, 5'd0, 32'd0));
    drive(1'b1, OpJr, 5'd0, 1'b0, 1'b0, 1'b0);
    step("jr", exp_of(FlJr | FlRtar, 2'd0, 3'd0, 5'd0, 32'd0));
    drive(1'b1, OpBlt, 5'd0, 1'b0, 1'b0, 1'b0);
    step("blt", exp_of(FlBlt | FlRtar, 2'd0, 3'd0, 5'd0, 32'd0));
    drive(1'b1, OpSetx, 5'd0, 1'b0, 1'b0, 1'b0);
    step("setx", exp_of(FlSetx | FlRwe, 2'd1, 3'd4, 5'd0, 32'd0));
    drive(1'b1, OpBex, 5'd0, 1'b0, 1'b0, 1'b0);
    step("bex", exp_of(FlBex, 2'd0, 3'd0, 5'd0, 32'd0));
    drive(1'b1, 5'b11111, 5'd6, 1'b1, 1'b0, 1'b0);
    step("op_1f", '0);
    drive(1'b1, 5'b01001, 5'd0, 1'b1, 1'b0, 1'b0);
    step("op_09", '0);

    // mul, ready after 3 wait cycles; instructions and bare md_exception ignored while waiting
    drive(1'b1, OpR, 5'd6, 1'b0, 1'b0, 1'b0);
    step("mul_issue", exp_of(FlMult | FlStall, 2'd0, 3'd0, 5'd6, 32'd0));
    for (int i = 0; i < 3; i++) begin
      drive(1'b1, OpAddi, 5'd0, 1'b1, 1'b0, 1'b1);
      step("mul_wait", exp_of(FlStall, 2'd0, 3'd0, 5'd0, 32'd0));
    end
    drive(1'b0, OpR, 5'd0, 1'b0, 1'b1, 1'b0);
    step("mul_done", exp_of(FlRwe, 2'd0, 3'd2, 5'd0, 32'd0));
    drive(1'b0, OpR, 5'd0, 1'b0, 1'b1, 1'b1);
    step("idle_ready", '0);

    // div with exception at minimum occupancy
    drive(1'b1, OpR, 5'd7, 1'b0, 1'b0, 1'b0);
    step("div_issue", exp_of(FlDiv | FlStall, 2'd0, 3'd0, 5'd7, 32'd0));
    drive(1'b0, OpR, 5'd0, 1'b0, 1'b1, 1'b1);
    step("div_exc", exp_of(FlRwe, 2'd1, 3'd3, 5'd0, 32'd5));

    // mul issued while md_ready already high (ignored in IDLE), then exception
    drive(1'b1, OpR, 5'd6, 1'b0, 1'b1, 1'b0);
    step("mul_issue_rdy", exp_of(FlMult | FlStall, 2'd0, 3'd0, 5'd6, 32'd0));
    drive(1'b0, OpR, 5'd0, 1'b0, 1'b1, 1'b1);
    step("mul_exc", exp_of(FlRwe, 2'd1, 3'd3, 5'd0, 32'd4));

`ifdef MULTICYCLE_CTRL_TIMEOUT_EN
    drive(1'b1, OpR, 5'd6, 1'b0, 1'b0, 1'b0);
    step("to_issue", exp_of(FlMult | FlStall, 2'd0, 3'd0, 5'd6, 32'd0));
    for (int i = 0; i < int'(MaxCycles) - 1; i++) begin
      drive(1'b0, OpR, 5'd0, 1'b0, 1'b0, 1'b0);
      step("to_wait", exp_of(FlStall, 2'd0, 3'd0, 5'd0, 32'd0));
    end
    step("md_timeout", exp_of(FlRwe, 2'd1, 3'd3, 5'd0, 32'd6));
    drive(1'b1, OpR, 5'd0, 1'b0, 1'b0, 1'b0);
    step("post_to_add", exp_of(FlRwe, 2'd0, 3'd0, 5'd0, 32'd0));
    drive(1'b1, OpR, 5'd7, 1'b0, 1'b0, 1'b0);
    step("to2_issue", exp_of(FlDiv | FlStall, 2'd0, 3'd0, 5'd7, 32'd0));
    for (int i = 0; i < int'(MaxCycles) - 1; i++) begin
      drive(1'b0, OpR, 5'd0, 1'b0, 1'b0, 1'b0);
      step("to2_wait", exp_of(FlStall, 2'd0, 3'd0, 5'd0, 32'd0));
    end
    drive(1'b0, OpR, 5'd0, 1'b0, 1'b1, 1'b0);
    step("ready_beats_to", exp_of(FlRwe, 2'd0, 3'd2, 5'd0, 32'd0));
`endif

    // Long wait (no timeout build waits forever), aborted by reset
    drive(1'b1, OpR, 5'd6, 1'b0, 1'b0, 1'b0);
    step("long_issue", exp_of(FlMult | FlStall, 2'd0, 3'd0, 5'd6, 32'd0));
`ifdef MULTICYCLE_CTRL_TIMEOUT_EN
    for (int i = 0; i < 3; i++) begin
`else
    for (int i = 0; i < 100; i++) begin
`endif
      drive(1'b0, OpR, 5'd0, 1'b0, 1'b0, 1'b0);
      step("long_wait", exp_of(FlStall, 2'd0, 3'd0, 5'd0, 32'd0));
    end
    reset = 1'b0;
    drive(1'b0, OpR, 5'd0, 1'b0, 1'b1, 1'b0);
    step("rst_abort", '0);
    reset = 1'b1;
    drive(1'b0, OpR, 5'd0, 1'b0, 1'b1, 1'b0);
    step("after_abort", '0);
    drive(1'b1, OpR, 5'd0, 1'b0, 1'b0, 1'b0);
    step("final_add", exp_of(FlRwe, 2'd0, 3'd0, 5'd0, 32'd0));

    @(negedge clock);
    #1;
    check_value("sb_drain", 56'(exp_q.size()), 56'd0);
    $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
    $finish;
  end

endmodule
